// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RISC-V controller.
// State, opcode, ALU, immediate and mux-select codes live here.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXE_R,
    S_EXE_I,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_LUI
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_RTYPE,
    ALUOP_ITYPE
  } aluop_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_RESULT = 1'b1;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RD1   = 2'd2;

  localparam logic [1:0] SRCB_RD2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [1:0] RES_ALUOUT    = 2'd0;
  localparam logic [1:0] RES_DATA      = 2'd1;
  localparam logic [1:0] RES_ALURESULT = 2'd2;
  localparam logic [1:0] RES_IMM       = 2'd3;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [2:0] imm_src;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  function automatic logic [2:0] decode_imm(
    input logic [6:0] op
  );
    return (op == OP_JAL) ? IMM_J : IMM_B;
  endfunction

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// Maps the ALU-op class plus funct3/funct7b5 onto an ALUControl code.
// Only R-type honours funct7b5 to turn add into sub.
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  aluop_e     aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  logic is_sub;

  always_comb begin
    is_sub      = (aluop == ALUOP_RTYPE) && funct7b5;
    alu_control = ALU_ADD;
    unique case (aluop)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      default: begin
        unique case (funct3)
          3'b000:  alu_control = is_sub ? ALU_SUB
                                        : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b100:  alu_control = ALU_XOR;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle RISC-V main controller: sequences fetch, decode,
// execute, memory and write-back and drives the datapath selects.
module mc_controller
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       neg,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       instr_done,
  output logic       illegal
);

  state_e state_q, state_d;
  ctrl_t  ctl;
  aluop_e aluop;
  logic   take;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    unique case (funct3)
      3'b000:  take = zero;
      3'b001:  take = ~zero;
      3'b100:  take = neg;
      3'b101:  take = ~neg;
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    ctl     = '0;
    aluop   = ALUOP_ADD;
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        ctl.adr_src    = ADR_PC;
        ctl.alu_src_a  = SRCA_PC;
        ctl.alu_src_b  = SRCB_FOUR;
        ctl.result_src = RES_ALURESULT;
        ctl.ir_write   = mem_ready;
        ctl.pc_write   = mem_ready;
        state_d = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ctl.alu_src_a = SRCA_OLDPC;
        ctl.alu_src_b = SRCB_IMM;
        ctl.imm_src   = decode_imm(op);
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:  state_d = S_EXE_R;
          OP_ITYPE:  state_d = S_EXE_I;
          OP_BRANCH: state_d = S_BRANCH;
          OP_JAL:    state_d = S_JAL;
          OP_JALR:   state_d = S_JALR;
          OP_LUI:    state_d = S_LUI;
          default: begin
            ctl.illegal = 1'b1;
            state_d     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ctl.alu_src_a = SRCA_RD1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.imm_src   = (op == OP_STORE) ? IMM_S
                                         : IMM_I;
        state_d = (op == OP_STORE) ? S_MEMWRITE
                                   : S_MEMREAD;
      end
      S_MEMREAD: begin
        ctl.adr_src    = ADR_RESULT;
        ctl.result_src = RES_ALUOUT;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ctl.result_src = RES_DATA;
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWRITE: begin
        ctl.adr_src    = ADR_RESULT;
        ctl.result_src = RES_ALUOUT;
        ctl.mem_write  = mem_ready;
        ctl.instr_done = mem_ready;
        state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXE_R: begin
        ctl.alu_src_a = SRCA_RD1;
        ctl.alu_src_b = SRCB_RD2;
        aluop   = ALUOP_RTYPE;
        state_d = S_ALUWB;
      end
      S_EXE_I: begin
        ctl.alu_src_a = SRCA_RD1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.imm_src   = IMM_I;
        aluop   = ALUOP_ITYPE;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        ctl.result_src = RES_ALUOUT;
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ctl.alu_src_a  = SRCA_RD1;
        ctl.alu_src_b  = SRCB_RD2;
        ctl.result_src = RES_ALUOUT;
        ctl.pc_write   = take;
        ctl.instr_done = 1'b1;
        aluop   = ALUOP_SUB;
        state_d = S_FETCH;
      end
      S_JALR: begin
        ctl.alu_src_a = SRCA_RD1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.imm_src   = IMM_I;
        state_d = S_JAL;
      end
      S_JAL: begin
        ctl.alu_src_a  = SRCA_OLDPC;
        ctl.alu_src_b  = SRCB_FOUR;
        ctl.result_src = RES_ALUOUT;
        ctl.pc_write   = 1'b1;
        state_d = S_ALUWB;
      end
      S_LUI: begin
        ctl.imm_src    = IMM_U;
        ctl.result_src = RES_IMM;
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  alu_decoder u_alu_dec (
    .aluop       (aluop),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (ALUControl)
  );

  // Reset suppresses every side effect in the same cycle.
  assign PCWrite    = ctl.pc_write   & ~rst;
  assign IRWrite    = ctl.ir_write   & ~rst;
  assign MemWrite   = ctl.mem_write  & ~rst;
  assign RegWrite   = ctl.reg_write  & ~rst;
  assign instr_done = ctl.instr_done & ~rst;
  assign illegal    = ctl.illegal    & ~rst;
  assign AdrSrc     = ctl.adr_src;
  assign ALUSrcA    = ctl.alu_src_a;
  assign ALUSrcB    = ctl.alu_src_b;
  assign ResultSrc  = ctl.result_src;
  assign ImmSrc     = ctl.imm_src;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-instruction cycle
// sequences are expanded into expected output vectors.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       neg = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, IRWrite, MemWrite, RegWrite;
  logic       AdrSrc;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0] ALUControl, ImmSrc;
  logic       instr_done, illegal;

  mc_controller dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .neg        (neg),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .instr_done (instr_done),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JL   = 7'b1101111;
  localparam logic [6:0] JLR  = 7'b1100111;
  localparam logic [6:0] LU   = 7'b0110111;

  // enables and pulses only: {PCW,IRW,MW,RW,...,done,ill}
  localparam logic [18:0] EN_MASK = {4'hF, 13'b0, 2'b11};
  localparam logic [18:0] ALL     = '1;

  logic [18:0] got;
  assign got = {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc,
                ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
                ImmSrc, instr_done, illegal};

  logic [18:0] exp_q[$];
  logic [18:0] msk_q[$];
  string       tag_q[$];

  int errors = 0;
  int checks = 0;

  logic [6:0] i_op;
  logic [2:0] i_f3;
  logic       i_f7;
  logic       z_v, n_v;
  int         zf = -1;
  int         cyc_n;
  int         abort_at;
  bit         aborted;

  function automatic logic [18:0] mk(
    input logic pcw, input logic irw, input logic mw,
    input logic rw, input logic adr,
    input logic [1:0] a, input logic [1:0] b,
    input logic [1:0] rs, input logic [2:0] alu,
    input logic [2:0] imm, input logic done,
    input logic ill
  );
    return {pcw, irw, mw, rw, adr, a, b, rs, alu, imm,
            done, ill};
  endfunction

  function automatic logic [2:0] alu_ref(
    input logic [2:0] f3, input logic f7, input bit is_r
  );
    case (f3)
      3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b100;
      3'b100:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic br_ref(
    input logic [2:0] f3, input logic z, input logic n
  );
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return n;
      3'b101:  return !n;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit legal_op(input logic [6:0] o);
    return o inside {LW, SW, RT, IT, BR, JL, JLR, LU};
  endfunction

  task automatic rf();
    z_v = (zf < 0) ? 1'($urandom_range(0, 1)) : zf[0];
    n_v = 1'($urandom_range(0, 1));
  endtask

  function automatic logic pick_mr(input int waits, input int k);
    if (waits < 0) return ($urandom_range(0, 3) != 0);
    return (k >= waits);
  endfunction

  task automatic cyc(
    input logic mr, input logic [18:0] v, input string tag
  );
    @(posedge clk);
    #1;
    cyc_n++;
    op = i_op;
    funct3 = i_f3;
    funct7b5 = i_f7;
    mem_ready = mr;
    zero = z_v;
    neg = n_v;
    if (cyc_n == abort_at) begin
      rst = 1'b1;
      aborted = 1'b1;
      exp_q.push_back('0);
      msk_q.push_back(EN_MASK);
      tag_q.push_back({tag, "_rst"});
    end else begin
      rst = 1'b0;
      exp_q.push_back(v);
      msk_q.push_back(ALL);
      tag_q.push_back(tag);
    end
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b1;
      mem_ready = 1'b1;
      exp_q.push_back('0);
      msk_q.push_back(EN_MASK);
      tag_q.push_back("reset");
    end
  endtask

  task automatic run_instr(
    input logic [6:0] o, input logic [2:0] f3,
    input logic f7, input int waits, input int ab
  );
    logic mr;
    int   k;
    i_op = o;
    i_f3 = f3;
    i_f7 = f7;
    cyc_n = 0;
    abort_at = ab;
    aborted = 0;
    k = 0;
    do begin
      mr = (waits < 0) ? pick_mr(-1, 0) : 1'b1;
      rf();
      cyc(mr, mk(mr, mr, 0, 0, 0, 2'd0, 2'd2, 2'd2, 3'd0,
                 3'd0, 0, 0), "fetch");
      if (aborted) return;
    end while (!mr);
    rf();
    cyc(1'($urandom_range(0, 1)),
        mk(0, 0, 0, 0, 0, 2'd1, 2'd1, 2'd0, 3'd0,
           (o == JL) ? 3'd3 : 3'd2, 0, !legal_op(o)),
        "decode");
    if (aborted || !legal_op(o)) return;
    case (o)
      LW, SW: begin
        rf();
        cyc(1'b1, mk(0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 3'd0,
                     (o == SW) ? 3'd1 : 3'd0, 0, 0), "memadr");
        if (aborted) return;
        do begin
          mr = pick_mr(waits, k);
          k++;
          rf();
          if (o == SW)
            cyc(mr, mk(0, 0, mr, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0,
                       3'd0, mr, 0), "memwrite");
          else
            cyc(mr, mk(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0,
                       3'd0, 0, 0), "memread");
          if (aborted) return;
        end while (!mr);
        if (o == LW) begin
          rf();
          cyc(1'b1, mk(0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd1, 3'd0,
                       3'd0, 1, 0), "memwb");
        end
        return;
      end
      RT, IT: begin
        rf();
        cyc(1'b1, mk(0, 0, 0, 0, 0, 2'd2,
                     (o == RT) ? 2'd0 : 2'd1, 2'd0,
                     alu_ref(f3, f7, o == RT), 3'd0, 0, 0),
            (o == RT) ? "exe_r" : "exe_i");
        if (aborted) return;
      end
      BR: begin
        rf();
        cyc(1'b1, mk(br_ref(f3, z_v, n_v), 0, 0, 0, 0, 2'd2,
                     2'd0, 2'd0, 3'd1, 3'd0, 1, 0), "branch");
        return;
      end
      LU: begin
        rf();
        cyc(1'b1, mk(0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd3, 3'd0,
                     3'd4, 1, 0), "lui");
        return;
      end
      default: begin
        if (o == JLR) begin
          rf();
          cyc(1'b1, mk(0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 3'd0,
                       3'd0, 0, 0), "jalr");
          if (aborted) return;
        end
        rf();
        cyc(1'b1, mk(1, 0, 0, 0, 0, 2'd1, 2'd2, 2'd0, 3'd0,
                     3'd0, 0, 0), "jal");
        if (aborted) return;
      end
    endcase
    rf();
    cyc(1'b1, mk(0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0,
                 3'd0, 1, 0), "aluwb");
  endtask

  always @(negedge clk) begin
    logic [18:0] e, m;
    string       t;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if ((got & m) !== (e & m)) begin
        errors++;
        $display("FAIL %s got=%b exp=%b", t, got & m, e & m);
      end
    end
  end

  logic [6:0] ops[8] = '{LW, SW, RT, IT, BR, JL, JLR, LU};

  initial begin
    logic [6:0] o;
    reset_cycles(2);
    run_instr(RT, 3'b000, 1'b0, 0, 0);
    run_instr(RT, 3'b000, 1'b1, 0, 0);
    run_instr(IT, 3'b000, 1'b1, 0, 0);
    run_instr(LW, 3'b010, 1'b0, 3, 0);
    run_instr(SW, 3'b010, 1'b0, 2, 0);
    zf = 1;
    run_instr(BR, 3'b000, 1'b0, 0, 0);
    run_instr(BR, 3'b001, 1'b0, 0, 0);
    zf = -1;
    run_instr(JLR, 3'b000, 1'b0, 0, 0);
    run_instr(JL, 3'b000, 1'b0, 0, 0);
    run_instr(LU, 3'b000, 1'b0, 0, 0);
    run_instr(7'b1111111, 3'b000, 1'b0, 0, 0);
    run_instr(SW, 3'b010, 1'b0, 0, 4);
    run_instr(RT, 3'b111, 1'b0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) o = 7'($urandom);
      else o = ops[$urandom_range(0, 7)];
      run_instr(o, 3'($urandom), 1'($urandom_range(0, 1)),
                -1,
                ($urandom_range(0, 19) == 0)
                  ? $urandom_range(1, 5) : 0);
    end
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
